// File: rtl/mem_access.sv
// mem_access: sequences direct and indirect data-memory reads/writes with an ack timeout
// Ports: clk, rst (asynchronous, active-low)
//        enable_memaccess, mem_state, M_Addr, M_Data : operation request from execute
//        Data_addr, Data_din, Data_req, Data_we      : memory request (out)
//        Data_dout, Data_ack                         : memory response (in)
//        memout                                      : last successfully read word
//        busy, done, err                             : status; err pulses with done on abort
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_memaccess,
    input  logic [1:0]  mem_state,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    input  logic [15:0] Data_dout,
    input  logic        Data_ack,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_req,
    output logic        Data_we,
    output logic [15:0] memout,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, PTR, GAP, ACC, DONE} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_addr, r_data, r_ptr, r_memout;
    logic [1:0]  r_op;
    logic [7:0]  r_cnt;
    logic        r_err, w_timeout;

    // Abort on the edge where the counter would reach TIMEOUT; an ack on that same edge wins.
    assign w_timeout = Data_req && !Data_ack && r_cnt == 8'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = enable_memaccess ? (mem_state[1] ? PTR : ACC) : IDLE;
            PTR:     w_next = Data_ack ? GAP : (w_timeout ? DONE : PTR);
            GAP:     w_next = ACC;
            ACC:     w_next = (Data_ack || w_timeout) ? DONE : ACC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_addr   <= 16'h0;
            r_data   <= 16'h0;
            r_ptr    <= 16'h0;
            r_memout <= 16'h0;
            r_op     <= 2'b00;
            r_cnt    <= 8'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && enable_memaccess) begin
                r_addr <= M_Addr;
                r_data <= M_Data;
                r_op   <= mem_state;
            end
            // The counter rests at zero whenever no request is pending, so it is clear on entry to PTR/ACC.
            r_cnt <= (Data_req && !Data_ack) ? r_cnt + 8'd1 : 8'd0;
            r_err <= w_timeout || (r_err && r_state != DONE);
            if (r_state == PTR && Data_ack)
                r_ptr <= Data_dout;
            if (r_state == ACC && Data_ack && !r_op[0])
                r_memout <= Data_dout;
        end
    end

    assign Data_req  = r_state == PTR || r_state == ACC;
    assign Data_we   = r_state == ACC && r_op[0];
    assign Data_din  = Data_we ? r_data : 16'h0;
    // Indirect ops (mem_state[1]) use the fetched pointer for the final access.
    assign Data_addr = r_state == PTR ? r_addr : r_state == ACC ? (r_op[1] ? r_ptr : r_addr) : 16'h0;
    assign memout    = r_memout;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign err       = done && r_err;
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: consecutive un-acked request cycles before an access is aborted; legal range 2..255.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 enable_memaccess  in  1  start strobe; sampled only in IDLE.
REQ-006 mem_state  in  2  operation: 0 read (LD/LDR), 1 write (ST/STR), 2 indirect read (LDI), 3 indirect write (STI).
REQ-007 M_Addr  in  16  effective address from execute.
REQ-008 M_Data  in  16  store data from execute.
REQ-009 Data_dout  in  16  memory read data; valid when Data_ack=1.
REQ-010 Data_ack  in  1  memory completion; meaningful only while Data_req=1.
REQ-011 Data_addr  out  16  memory address.
REQ-012 Data_din  out  16  memory write data.
REQ-013 Data_req  out  1  memory request.
REQ-014 Data_we  out  1  1 = write, 0 = read.
REQ-015 memout  out  16  last successfully read word; feeds writeback.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  one-cycle pulse, coincident with done, on timeout abort.

Function
REQ-019 States: IDLE, PTR (indirect pointer read), GAP, ACC (final access), DONE.
REQ-020 IDLE with enable_memaccess=1 at an edge: capture M_Addr, M_Data and mem_state; go to PTR for states 2/3, ACC for states 0/1.
REQ-021 Inputs are ignored while busy=1; enable_memaccess in DONE is also ignored.
REQ-022 PTR: Data_req=1, Data_we=0, Data_addr=captured M_Addr; on Data_ack=1, latch Data_dout as pointer and go to GAP.
REQ-023 GAP: one cycle, Data_req=0; then go to ACC with Data_addr=pointer.
REQ-024 ACC: Data_req=1; Data_we=1 only for mem_state 1/3; Data_din=captured M_Data for writes, 0 otherwise; Data_addr=captured address (direct) or pointer (indirect).
REQ-025 Data_addr, Data_din and Data_we are held stable while Data_req=1 until the acking edge.
REQ-026 ACC with Data_ack=1: for reads, memout<=Data_dout at that edge; go to DONE.
REQ-027 Writes never change memout; memout holds its value until the next successful read.
REQ-028 DONE: done=1 for one cycle, Data_req=0; then go to IDLE.
REQ-029 Data_ack is ignored whenever Data_req=0.
REQ-030 Timeout counter clears on entry to PTR or ACC and increments each cycle in which Data_req=1 and Data_ack=0.
REQ-031 When the counter reaches TIMEOUT, abort from PTR or ACC: go directly to DONE with err=1; memout is unchanged; for indirect ops the second access is not issued.
REQ-032 Data_ack=1 on the same edge the counter would reach TIMEOUT counts as success, not abort.
REQ-033 Latency, enable edge to done, with immediate ack: direct op 2 cycles; indirect op 4 cycles.
REQ-034 Minimum spacing between accepted enables is 3 cycles for direct ops.

Reset
REQ-035 rst=0 asynchronously forces IDLE and clears the pointer, the timeout counter and all captured registers.
REQ-036 During reset all outputs are 0: Data_addr, Data_din, Data_req, Data_we, memout, busy, done, err.
REQ-037 Reset mid-operation abandons the access with no done pulse; memout returns to 0.
REQ-038 After rst deasserts, the first edge may accept enable_memaccess.

Verification
REQ-039 Direct read: mem_state=0, M_Addr=0x3000, ack 1 cycle after request with Data_dout=0xBEEF -> Data_addr=0x3000, Data_we=0, done 2 cycles after enable, memout=0xBEEF.
REQ-040 Direct write: mem_state=1, M_Addr=0x3001, M_Data=0x1234, ack after 3 wait cycles -> Data_we=1, Data_din=0x1234 stable throughout, done once, memout unchanged.
REQ-041 Indirect read: mem_state=2, M_Addr=0x3002 holds 0x4000, 0x4000 holds 0x00AA -> request at 0x3002, one idle GAP cycle, request at 0x4000, memout=0x00AA, done 4 cycles after enable.
REQ-042 Timeout: TIMEOUT=16, mem_state=0, never ack -> Data_req high 16 cycles, then done=1 and err=1 together, memout unchanged; a repeat run with ack on the 16th cycle -> err=0.
REQ-043 Robustness: enable pulses while busy and spurious Data_ack while Data_req=0 -> no effect; rst=0 mid-ACC -> all outputs 0 immediately, no done.
